// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit arbiter.
package i2s_pkg;

  localparam int DW_DEFAULT = 16;
  localparam logic [15:0] UNDERRUN_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    MODE_S0  = 2'd0,
    MODE_S1  = 2'd1,
    MODE_RR  = 2'd2,
    MODE_MIX = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_S0   = 2'b01,
    SRC_S1   = 2'b10,
    SRC_MIX  = 2'b11
  } src_e;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector for the transmitter word clock.
// Both edges are flagged combinationally in the cycle the new level is seen.
module edge_detect (
  input  logic clk_i2s,
  input  logic reset_n,
  input  logic sig,
  output logic fall,
  output logic rise
);

  logic sig_q;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i2s or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  assign fall = sig_q & ~sig;
  assign rise = ~sig_q & sig;

endmodule

// File: rtl/i2s_tx_arbiter.sv
// Two-source sample arbiter feeding an I2S transmitter, framed by tx_lrclk.
// Optional mixing in mode 3 is built only when I2S_TX_MIX_EN is defined.
module i2s_tx_arbiter
  import i2s_pkg::*;
#(
  parameter int DW            = DW_DEFAULT,
  parameter bit UNDERRUN_HOLD = 1'b0
) (
  input  logic          clk_i2s,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic          tx_lrclk,
  input  logic          s0_valid,
  input  logic          s1_valid,
  output logic          s0_ready,
  output logic          s1_ready,
  input  logic [DW-1:0] s0_data_l,
  input  logic [DW-1:0] s0_data_r,
  input  logic [DW-1:0] s1_data_l,
  input  logic [DW-1:0] s1_data_r,
  output logic [DW-1:0] tx_data_l,
  output logic [DW-1:0] tx_data_r,
  output logic          underrun,
  output logic [15:0]   underrun_cnt,
  output logic [1:0]    active_src
);

  logic   fall, rise;
  state_e state;
  mode_e  mode_q;
  logic   armed;
  logic   rr_ptr;          // 0: s0 is next in round-robin, 1: s1 is next
  logic   cap0, cap1;
  logic [DW-1:0] st0_l, st0_r, st1_l, st1_r;

  logic   mix_mode, rr_mode;
  logic   elig0, elig1, req_open, take0, take1, go_hold;
  logic [DW-1:0] nxt_l, nxt_r;
  src_e   nxt_src;

  edge_detect u_lrclk_edge (
    .clk_i2s (clk_i2s),
    .reset_n (reset_n),
    .sig     (tx_lrclk),
    .fall    (fall),
    .rise    (rise)
  );

`ifdef I2S_TX_MIX_EN
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s[DW-1:0];
  endfunction

  assign mix_mode = (mode_q == MODE_MIX);
`else
  assign mix_mode = 1'b0;
`endif

  assign rr_mode = (mode_q == MODE_RR) || ((mode_q == MODE_MIX) && !mix_mode);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    elig0 = 1'b0;
    elig1 = 1'b0;
    case (mode_q)
      MODE_S0: elig0 = 1'b1;
      MODE_S1: elig1 = 1'b1;
      default: begin
        if (mix_mode) begin
          elig0 = 1'b1;
          elig1 = 1'b1;
        end else if (!rr_ptr) begin
          // Preferred source keeps the slot unless only the other one is offering.
          elig1 = ~s0_valid & s1_valid;
          elig0 = ~elig1;
        end else begin
          elig0 = ~s1_valid & s0_valid;
          elig1 = ~elig0;
        end
      end
    endcase
  end

  // The rise cycle closes the window so nothing lands after the frame is latched.
  assign req_open = (state == ST_REQ) && enable && !rise;
  assign s0_ready = req_open & elig0 & ~cap0;
  assign s1_ready = req_open & elig1 & ~cap1;
  assign take0    = s0_valid & s0_ready;
  assign take1    = s1_valid & s1_ready;
  assign go_hold  = mix_mode ? ((cap0 | take0) & (cap1 | take1)) : (take0 | take1);

  always_comb begin
    nxt_l   = st1_l;
    nxt_r   = st1_r;
    nxt_src = SRC_S1;
`ifdef I2S_TX_MIX_EN
    if (mix_mode) begin
      // Staging is zeroed at each fall, so a missing source adds zero.
      nxt_l   = sat_add(st0_l, st1_l);
      nxt_r   = sat_add(st0_r, st1_r);
      nxt_src = SRC_MIX;
    end else
`endif
    if (cap0) begin
      nxt_l   = st0_l;
      nxt_r   = st0_r;
      nxt_src = SRC_S0;
    end
  end

  // NOTE: staging registers sit on the async reset so a reset mid-frame can never leak old data.
  always_ff @(posedge clk_i2s or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_S0;
      armed        <= 1'b0;
      rr_ptr       <= 1'b0;
      cap0         <= 1'b0;
      cap1         <= 1'b0;
      st0_l        <= '0;
      st0_r        <= '0;
      st1_l        <= '0;
      st1_r        <= '0;
      tx_data_l    <= '0;
      tx_data_r    <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      active_src   <= SRC_NONE;
    end else begin
      underrun <= 1'b0;
      if (fall) begin
        armed  <= 1'b1;
        mode_q <= mode_e'(mode);
        cap0   <= 1'b0;
        cap1   <= 1'b0;
        st0_l  <= '0;
        st0_r  <= '0;
        st1_l  <= '0;
        st1_r  <= '0;
        state  <= enable ? ST_REQ : ST_IDLE;
      end else begin
        if (take0) begin
          cap0  <= 1'b1;
          st0_l <= s0_data_l;
          st0_r <= s0_data_r;
        end
        if (take1) begin
          cap1  <= 1'b1;
          st1_l <= s1_data_l;
          st1_r <= s1_data_r;
        end
        if (rr_mode && take0)      rr_ptr <= 1'b1;
        else if (rr_mode && take1) rr_ptr <= 1'b0;

        if (rise || !enable)                     state <= ST_IDLE;
        else if (state == ST_REQ && go_hold)     state <= ST_HOLD;

        if (rise && armed) begin
          if (enable && state != ST_IDLE && (cap0 || cap1)) begin
            tx_data_l  <= nxt_l;
            tx_data_r  <= nxt_r;
            active_src <= nxt_src;
          end else if (enable && state != ST_IDLE) begin
            underrun <= 1'b1;
            if (underrun_cnt != UNDERRUN_CNT_MAX) underrun_cnt <= underrun_cnt + 16'd1;
            if (!UNDERRUN_HOLD) begin
              tx_data_l <= '0;
              tx_data_r <= '0;
            end
            active_src <= SRC_NONE;
          end else begin
            // Disabled frames go silent without being counted as underruns.
            tx_data_l  <= '0;
            tx_data_r  <= '0;
            active_src <= SRC_NONE;
          end
        end
      end
    end
  end

endmodule
